maze_wall_probe: RTL and testbench

//  Upstream of the player motion stage. Produces its valid_dir input (1 = open, no wall) from the current sprite position.

---
 rtl/maze_pkg.sv | 41 ++++
 rtl/maze_tile_addr.sv | 69 ++++++
 rtl/maze_wall_probe.sv | 129 ++++++++++++
 tb/tb_maze_wall_probe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared maze geometry, direction bit indices and probe FSM codes.
// Used by maze_wall_probe and maze_tile_addr (also the ghost AI stage).
package maze_pkg;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  localparam int TILE_SHIFT  = 4;
  localparam int MAZE_COLS   = 40;
  localparam int MAZE_ROWS   = 30;
  localparam int MAZE_ADDR_W = 11;
  localparam int POS_X_W     = 10;
  localparam int POS_Y_W     = 9;

  typedef logic [1:0] dir_t;
  typedef logic [2:0] probe_state_t;

  localparam probe_state_t S_CAP    = 3'd0;
  localparam probe_state_t S_L      = 3'd1;
  localparam probe_state_t S_R      = 3'd2;
  localparam probe_state_t S_U      = 3'd3;
  localparam probe_state_t S_D      = 3'd4;
  localparam probe_state_t S_LAST   = 3'd5;
  localparam probe_state_t S_COMMIT = 3'd6;

  // Neighbour probed while the FSM sits in a given address state.
  function automatic dir_t state_dir(probe_state_t s);
    dir_t d;
    d = dir_t'(DIR_LEFT);
    unique case (s)
      S_R:     d = dir_t'(DIR_RIGHT);
      S_U:     d = dir_t'(DIR_UP);
      S_D:     d = dir_t'(DIR_DOWN);
      default: d = dir_t'(DIR_LEFT);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/maze_tile_addr.sv
// maze_tile_addr: (col,row,dir) -> ROM address of the neighbour tile + off-maze flag.
// Ports: i_col, i_row, i_dir in; o_addr (row*COLS+col), o_off (neighbour outside maze) out.
module maze_tile_addr #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 11,
  parameter int COL_W  = 6,
  parameter int ROW_W  = 5,
  parameter int WRAP_X = 1
) (
  input  logic [COL_W-1:0]  i_col,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [1:0]        i_dir,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_off
);
  import maze_pkg::*;

  localparam logic [COL_W-1:0] L_COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] L_ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] L_COLS  = ADDR_W'(COLS);
  localparam logic              L_NOWRAP = (WRAP_X == 0);

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;

  always_comb begin
    w_col = i_col;
    w_row = i_row;
    o_off = 1'b0;
    unique case (i_dir)
      2'(DIR_LEFT): begin
        if (i_col == '0) begin
          // Tunnel: left of column 0 is the last column.
          w_col = L_COL_MAX;
          o_off = L_NOWRAP;
        end else begin
          w_col = i_col - 1'b1;
        end
      end
      2'(DIR_RIGHT): begin
        if (i_col == L_COL_MAX) begin
          w_col = '0;
          o_off = L_NOWRAP;
        end else begin
          w_col = i_col + 1'b1;
        end
      end
      2'(DIR_UP): begin
        if (i_row == '0) begin
          o_off = 1'b1;
        end else begin
          w_row = i_row - 1'b1;
        end
      end
      2'(DIR_DOWN): begin
        if (i_row == L_ROW_MAX) begin
          o_off = 1'b1;
        end else begin
          w_row = i_row + 1'b1;
        end
      end
    endcase
  end

  // Row product kept at full address width so legal rows never truncate.
  assign o_addr = ADDR_W'(w_row) * L_COLS + ADDR_W'(w_col);

endmodule

// File: rtl/maze_wall_probe.sv
// maze_wall_probe: snapshots sprite position, reads 4 neighbour wall bits, publishes open mask.
// Ports: clk, reset, enable, position_x/y, rom_addr/rom_data (registered ROM), valid_dir, valid_dir_stb.
module maze_wall_probe #(
  parameter int MAZE_COLS  = maze_pkg::MAZE_COLS,
  parameter int MAZE_ROWS  = maze_pkg::MAZE_ROWS,
  parameter int TILE_SHIFT = maze_pkg::TILE_SHIFT,
  parameter int ADDR_W     = maze_pkg::MAZE_ADDR_W,
  parameter int WRAP_X     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [9:0]        position_x,
  input  logic [8:0]        position_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic [3:0]        valid_dir,
  output logic              valid_dir_stb
);
  import maze_pkg::*;

  localparam int COL_W = 10 - TILE_SHIFT;
  localparam int ROW_W = 9 - TILE_SHIFT;

  probe_state_t      r_state;
  probe_state_t      w_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_ax;
  logic              r_ay;
  logic              r_off;
  logic [3:0]        r_wall;
  logic [3:0]        r_valid_dir;
  logic              r_stb;
  logic              w_probe;
  logic              w_off;
  logic              w_wall;
  logic [3:0]        w_mask;
  dir_t              w_dir;
  logic [ADDR_W-1:0] w_addr;

  assign w_dir   = state_dir(r_state);
  assign w_probe = (r_state == S_L) || (r_state == S_R) ||
                   (r_state == S_U) || (r_state == S_D);

  maze_tile_addr #(
    .COLS   (MAZE_COLS),
    .ROWS   (MAZE_ROWS),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .WRAP_X (WRAP_X)
  ) u_addr (
    .i_col  (r_col),
    .i_row  (r_row),
    .i_dir  (w_dir),
    .o_addr (w_addr),
    .o_off  (w_off)
  );

  assign rom_addr = w_probe ? w_addr : '0;

  // r_off tracks the address issued last cycle, aligned with rom_data.
  assign w_wall = rom_data | r_off;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CAP:    w_next = enable ? S_L : S_CAP;
      S_L:      w_next = S_R;
      S_R:      w_next = S_U;
      S_U:      w_next = S_D;
      S_D:      w_next = S_LAST;
      S_LAST:   w_next = S_COMMIT;
      S_COMMIT: w_next = S_CAP;
      default:  w_next = S_CAP;
    endcase
  end

  // Off-grid positions only allow motion along the axis they are aligned on.
  always_comb begin
    w_mask = 4'b0000;
    unique case ({r_ax, r_ay})
      2'b11:   w_mask = ~r_wall;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b1100;
      default: w_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CAP;
      r_col       <= '0;
      r_row       <= '0;
      r_ax        <= 1'b0;
      r_ay        <= 1'b0;
      r_off       <= 1'b0;
      r_wall      <= 4'b0000;
      r_valid_dir <= 4'b0000;
      r_stb       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_off   <= w_probe & w_off;
      r_stb   <= (r_state == S_COMMIT);
      unique case (r_state)
        S_CAP: begin
          if (enable) begin
            r_col <= position_x[9:TILE_SHIFT];
            r_row <= position_y[8:TILE_SHIFT];
            r_ax  <= (position_x[TILE_SHIFT-1:0] == '0);
            r_ay  <= (position_y[TILE_SHIFT-1:0] == '0);
          end
        end
        S_R:      r_wall[DIR_LEFT]  <= w_wall;
        S_U:      r_wall[DIR_RIGHT] <= w_wall;
        S_D:      r_wall[DIR_UP]    <= w_wall;
        S_LAST:   r_wall[DIR_DOWN]  <= w_wall;
        S_COMMIT: r_valid_dir       <= w_mask;
        default: ;
      endcase
    end
  end

  // Strobe and mask are registered on the same edge so they appear together.
  assign valid_dir     = r_valid_dir;
  assign valid_dir_stb = r_stb;

endmodule

// File: tb/tb_maze_wall_probe.sv
// tb_maze_wall_probe: randomized and directed checks of maze_wall_probe.
// Two instances share stimulus: one with the tunnel wrap, one without.
module tb_maze_wall_probe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [9:0]  position_x = '0;
  logic [8:0]  position_y = '0;
  logic [10:0] rom_addr;
  logic [10:0] rom_addr_nw;
  logic        rom_data = 1'b0;
  logic        rom_data_nw = 1'b0;
  logic [3:0]  valid_dir;
  logic [3:0]  valid_dir_nw;
  logic        stb;
  logic        stb_nw;

  logic mem [0:1199];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maze_wall_probe dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .position_x    (position_x),
    .position_y    (position_y),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .valid_dir     (valid_dir),
    .valid_dir_stb (stb)
  );

  maze_wall_probe #(.WRAP_X(0)) dut_nw (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .position_x    (position_x),
    .position_y    (position_y),
    .rom_addr      (rom_addr_nw),
    .rom_data      (rom_data_nw),
    .valid_dir     (valid_dir_nw),
    .valid_dir_stb (stb_nw)
  );

  function automatic logic rd(logic [10:0] a);
    return (a < 11'd1200) ? mem[a] : 1'b1;
  endfunction

  always @(posedge clk) begin
    rom_data    <= rd(rom_addr);
    rom_data_nw <= rd(rom_addr_nw);
  end

  function automatic bit open_at(int c, int r, bit wrap);
    int cc;
    cc = c;
    if (r < 0 || r >= 30) return 1'b0;
    if (cc < 0 || cc >= 40) begin
      if (!wrap) return 1'b0;
      cc = (cc + 40) % 40;
    end
    return (mem[r*40 + cc] == 1'b0);
  endfunction

  function automatic logic [3:0] model(int x, int y, bit wrap);
    int c;
    int r;
    bit ax;
    bit ay;
    c  = x / 16;
    r  = y / 16;
    ax = (x % 16) == 0;
    ay = (y % 16) == 0;
    if (ax && ay)
      return {open_at(c, r+1, wrap), open_at(c, r-1, wrap),
              open_at(c+1, r, wrap), open_at(c-1, r, wrap)};
    if (ay) return 4'b0011;
    if (ax) return 4'b1100;
    return 4'b0000;
  endfunction

  task automatic fill_rom(int mode);
    for (int i = 0; i < 1200; i++)
      case (mode)
        0:       mem[i] = 1'b0;
        1:       mem[i] = 1'b1;
        default: mem[i] = ($urandom_range(0, 2) == 0);
      endcase
  endtask

  task automatic set_pos(int x, int y);
    position_x = 10'(x);
    position_y = 9'(y);
  endtask

  // Returns negedges until the next strobe, or -1 on timeout.
  task automatic wait_stb(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!stb && cyc < 40);
    if (!stb) cyc = -1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    enable = 1'b1;
    fill_rom(0);
    set_pos(10'h090, 9'h110);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_dir !== 4'b0000 || stb !== 1'b0 || rom_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: vd=%b stb=%b addr=%0d need 0000 0 0",
               valid_dir, stb, rom_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_stb(cyc);
    checks++;
    if (cyc != 7) begin
      errors++;
      $display("FAIL reset_latency: got %0d need 7", cyc);
    end
    checks++;
    if (valid_dir !== 4'b1111 || valid_dir_nw !== 4'b1111) begin
      errors++;
      $display("FAIL open_rom: vd=%b vd_nw=%b need 1111", valid_dir, valid_dir_nw);
    end
  endtask

  task automatic test_addr_seq();
    int exp_a [4] = '{688, 690, 649, 729};
    int got_a [4];
    bit early;
    fill_rom(0);
    mem[688] = 1'b1;
    mem[649] = 1'b1;
    set_pos(10'h090, 9'h110);
    early = 1'b0;
    pulse_reset();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) got_a[k-1] = int'(rom_addr);
      if (k < 7 && stb) early = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_a[i] != exp_a[i]) begin
        errors++;
        $display("FAIL addr_seq[%0d]: got %0d need %0d", i, got_a[i], exp_a[i]);
      end
    end
    checks++;
    if (early || stb !== 1'b1 || valid_dir !== 4'b1010 || valid_dir_nw !== 4'b1010) begin
      errors++;
      $display("FAIL walls_l_u: early=%0b stb=%b vd=%b vd_nw=%b need 0 1 1010 1010",
               early, stb, valid_dir, valid_dir_nw);
    end
  endtask

  task automatic test_midtile();
    int cyc;
    int xs [2] = '{'h095, 'h090};
    int ys [2] = '{'h110, 'h113};
    logic [3:0] req [2] = '{4'b0011, 4'b1100};
    fill_rom(1);
    for (int i = 0; i < 2; i++) begin
      set_pos(xs[i], ys[i]);
      wait_stb(cyc);
      wait_stb(cyc);
      checks++;
      if (cyc != 7 || valid_dir !== req[i] || valid_dir_nw !== req[i]) begin
        errors++;
        $display("FAIL midtile[%0d]: cyc=%0d vd=%b vd_nw=%b need 7 %b",
                 i, cyc, valid_dir, valid_dir_nw, req[i]);
      end
    end
  endtask

  task automatic test_edges();
    int cyc;
    int a39;
    int a0;
    logic [3:0] e1;
    logic [3:0] e0;
    fill_rom(0);
    set_pos(0, 0);
    pulse_reset();
    @(negedge clk);
    a39 = int'(rom_addr);
    checks++;
    if (a39 != 39) begin
      errors++;
      $display("FAIL wrap_left_addr: got %0d need 39", a39);
    end
    wait_stb(cyc);
    e1 = model(0, 0, 1'b1);
    e0 = model(0, 0, 1'b0);
    checks++;
    if (valid_dir !== e1 || valid_dir_nw !== 4'b1010 || e0 !== 4'b1010) begin
      errors++;
      $display("FAIL corner_00: vd=%b vd_nw=%b need %b 1010", valid_dir, valid_dir_nw, e1);
    end
    set_pos(624, 464);
    pulse_reset();
    @(negedge clk);
    @(negedge clk);
    a0 = int'(rom_addr);
    checks++;
    if (a0 != 1160) begin
      errors++;
      $display("FAIL wrap_right_addr: got %0d need 1160", a0);
    end
    wait_stb(cyc);
    e1 = model(624, 464, 1'b1);
    e0 = model(624, 464, 1'b0);
    checks++;
    if (valid_dir !== e1 || valid_dir_nw !== e0) begin
      errors++;
      $display("FAIL corner_br: vd=%b vd_nw=%b need %b %b", valid_dir, valid_dir_nw, e1, e0);
    end
  endtask

  task automatic test_enable();
    int cyc;
    int nstb;
    bit moved;
    logic [3:0] held;
    fill_rom(0);
    set_pos(10'h090, 9'h110);
    enable = 1'b1;
    pulse_reset();
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_stb(cyc);
    checks++;
    if (cyc != 4 || valid_dir !== 4'b1111) begin
      errors++;
      $display("FAIL enable_drain: cyc=%0d vd=%b need 4 1111", cyc, valid_dir);
    end
    held = valid_dir;
    fill_rom(1);
    nstb = 0;
    moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (stb) nstb++;
      if (valid_dir !== held || rom_addr !== 11'd0) moved = 1'b1;
    end
    checks++;
    if (nstb != 0 || moved) begin
      errors++;
      $display("FAIL enable_hold: stbs=%0d moved=%0b need 0 0", nstb, moved);
    end
    enable = 1'b1;
    wait_stb(cyc);
    checks++;
    if (cyc != 7 || valid_dir !== model(10'h090, 9'h110, 1'b1)) begin
      errors++;
      $display("FAIL reenable: cyc=%0d vd=%b need 7 0000", cyc, valid_dir);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill_rom(0);
    set_pos(10'h090, 9'h110);
    enable = 1'b1;
    wait_stb(cyc);
    wait_stb(cyc);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_dir !== 4'b0000 || stb !== 1'b0 || rom_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: vd=%b stb=%b addr=%0d need 0000 0 0",
               valid_dir, stb, rom_addr);
    end
    reset = 1'b0;
    wait_stb(cyc);
    checks++;
    if (cyc != 7 || valid_dir !== 4'b1111) begin
      errors++;
      $display("FAIL reset_mid_restart: cyc=%0d vd=%b need 7 1111", cyc, valid_dir);
    end
    pulse_reset();
    repeat (2) @(negedge clk);
    set_pos(10'h095, 9'h110);
    wait_stb(cyc);
    checks++;
    if (cyc != 5 || valid_dir !== 4'b1111) begin
      errors++;
      $display("FAIL snapshot: cyc=%0d vd=%b need 5 1111", cyc, valid_dir);
    end
  endtask

  task automatic test_random();
    int cyc;
    int x;
    int y;
    logic [3:0] e1;
    logic [3:0] e0;
    enable = 1'b1;
    for (int it = 0; it < 25; it++) begin
      fill_rom(2);
      x = $urandom_range(0, 39) * 16;
      y = $urandom_range(0, 29) * 16;
      if ($urandom_range(0, 3) == 0) x += $urandom_range(1, 15);
      if ($urandom_range(0, 3) == 0) y += $urandom_range(1, 15);
      set_pos(x, y);
      e1 = model(x, y, 1'b1);
      e0 = model(x, y, 1'b0);
      wait_stb(cyc);
      wait_stb(cyc);
      checks++;
      if (cyc != 7) begin
        errors++;
        $display("FAIL back_to_back[%0d]: interval %0d need 7", it, cyc);
      end
      checks++;
      if (valid_dir !== e1) begin
        errors++;
        $display("FAIL rand_wrap[%0d] x=%0d y=%0d: got %b need %b", it, x, y, valid_dir, e1);
      end
      checks++;
      if (valid_dir_nw !== e0) begin
        errors++;
        $display("FAIL rand_nowrap[%0d] x=%0d y=%0d: got %b need %b",
                 it, x, y, valid_dir_nw, e0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_seq();
    test_midtile();
    test_edges();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
